// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operand width,
// iteration count, the decode op encoding, the control state encoding and
// small op-classification helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_W     = 32;
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/result bundle between decode/execute (master) and muldiv_unit
// (slave).
//   start      : request pulse, taken when the unit is idle or finishing
//   op         : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val     : multiplicand / dividend / MTHI-MTLO source
//   rt_val     : multiplier / divisor
//   cancel     : pipeline flush of the operation in flight
//   busy       : high from the cycle after acceptance through DONE
//   done       : one-cycle result pulse
//   hilo_d     : {hi, lo} result, valid while done=1
//   hilo_write : {HI, LO} write strobes, nonzero only while done=1
// -----------------------------------------------------------------------------
interface muldiv_if;
    import muldiv_pkg::*;

    logic                    start;
    logic [2:0]              op;
    logic [MULDIV_W-1:0]     rs_val;
    logic [MULDIV_W-1:0]     rt_val;
    logic                    cancel;
    logic                    busy;
    logic                    done;
    logic [2*MULDIV_W-1:0]   hilo_d;
    logic [1:0]              hilo_write;

    modport master (
        output start, op, rs_val, rt_val, cancel,
        input  busy, done, hilo_d, hilo_write
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel,
        output busy, done, hilo_d, hilo_write
    );

endinterface

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
// Conditional two's-complement negation, used for operand absolute values and
// for sign correction of product, quotient and remainder.
//   neg_i : negate when 1, pass through when 0
//   val_i : input value
//   val_o : neg_i ? -val_i : val_i
// -----------------------------------------------------------------------------
module muldiv_negate #(
    parameter int DATA_W = 32
) (
    input  logic              neg_i,
    input  logic [DATA_W-1:0] val_i,
    output logic [DATA_W-1:0] val_o
);

    logic signed [DATA_W-1:0] val_s;

    assign val_s = val_i;
    // The most negative value maps to itself, which is exactly what the
    // 0x80000000 absolute-value and 0x80000000 / -1 cases need.
    assign val_o = neg_i ? -val_s : val_s;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO pass-through. Produces a
// registered {hi, lo} value and per-half write strobes for one DONE cycle so
// the HI/LO register can sample them on the falling edge.
//   clk   : clock, rising-edge state changes
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave (start/op/rs_val/rt_val/cancel in,
//           busy/done/hilo_d/hilo_write out)
// Optional build macro: MULDIV_EARLY_OUT_EN -- a multiply leaves ITER as soon
// as the remaining multiplier bits are zero; divide latency is unaffected.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int W = MULDIV_W;

    muldiv_state_e   state_q;
    logic [2:0]      op_q;
    logic [W-1:0]    rs_q;
    logic [W-1:0]    rt_q;
    logic [W-1:0]    opb_q;       // multiplier, shifted right each step
    logic [2*W-1:0]  opa_q;       // multiplicand (shifted left) or divisor
    logic [2*W-1:0]  acc_q;       // product, or {remainder, quotient}
    logic [4:0]      cnt_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            div0_q;
    logic            busy_q;
    logic            done_q;
    logic [2*W-1:0]  hilo_d_q;
    logic [1:0]      hilo_write_q;

    logic            accept_d;
    logic            is_div_d;
    logic            is_signed_d;
    logic [W-1:0]    abs_rs_d;
    logic [W-1:0]    abs_rt_d;
    logic [2*W-1:0]  mul_acc_d;
    logic [W:0]      div_shift_d;
    logic [W:0]      div_diff_d;
    logic [2*W-1:0]  div_acc_d;
    logic            iter_last_d;
    logic [2*W-1:0]  prod_fix_d;
    logic [W-1:0]    quo_fix_d;
    logic [W-1:0]    rem_fix_d;
    logic [2*W-1:0]  result_d;

    // A new request can land in the DONE cycle as well as in IDLE; a
    // simultaneous cancel flushes it.
    assign accept_d    = bus.start && !bus.cancel &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign is_div_d    = op_is_div(op_q);
    assign is_signed_d = op_is_signed(op_q);

    muldiv_negate #(.DATA_W(W)) u_abs_rs (
        .neg_i (is_signed_d && rs_q[W-1]),
        .val_i (rs_q),
        .val_o (abs_rs_d)
    );

    muldiv_negate #(.DATA_W(W)) u_abs_rt (
        .neg_i (is_signed_d && rt_q[W-1]),
        .val_i (rt_q),
        .val_o (abs_rt_d)
    );

    // Shift-add multiply step.
    assign mul_acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;

    // Restoring divide step. The remainder is always below the divisor, so
    // bit W of the 33-bit trial difference is a reliable borrow flag.
    assign div_shift_d = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff_d  = div_shift_d - {1'b0, opa_q[W-1:0]};
    assign div_acc_d   = div_diff_d[W]
                       ? {div_shift_d[W-1:0], acc_q[W-2:0], 1'b0}
                       : {div_diff_d[W-1:0],  acc_q[W-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
    // After this step only opb_q[W-1:1] remains; if it is zero the product
    // is already final.
    assign iter_last_d = (cnt_q == 5'd0) ||
                         (!is_div_d && (opb_q[W-1:1] == '0));
`else
    assign iter_last_d = (cnt_q == 5'd0);
`endif

    muldiv_negate #(.DATA_W(2*W)) u_fix_prod (
        .neg_i (neg_res_q),
        .val_i (acc_q),
        .val_o (prod_fix_d)
    );

    muldiv_negate #(.DATA_W(W)) u_fix_quo (
        .neg_i (neg_res_q),
        .val_i (acc_q[W-1:0]),
        .val_o (quo_fix_d)
    );

    muldiv_negate #(.DATA_W(W)) u_fix_rem (
        .neg_i (neg_rem_q),
        .val_i (acc_q[2*W-1:W]),
        .val_o (rem_fix_d)
    );

    always_comb begin
        result_d = prod_fix_d;
        if (is_div_d) begin
            // Divide by zero bypasses sign correction: lo=all ones, hi=dividend.
            result_d = div0_q ? {rs_q, {W{1'b1}}} : {rem_fix_d, quo_fix_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div0_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hilo_d_q     <= '0;
            hilo_write_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    hilo_d_q     <= '0;
                    hilo_write_q <= '0;
                    if (accept_d) begin
                        if ((bus.op == OP_MTHI) || (bus.op == OP_MTLO)) begin
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b1;
                            hilo_d_q     <= {bus.rs_val, bus.rs_val};
                            hilo_write_q <= (bus.op == OP_MTHI) ? 2'b10 : 2'b01;
                        end else if (bus.op <= OP_DIVU) begin
                            state_q <= ST_PREP;
                            busy_q  <= 1'b1;
                            op_q    <= bus.op;
                            rs_q    <= bus.rs_val;
                            rt_q    <= bus.rt_val;
                        end
                    end
                end

                ST_PREP: begin
                    if (bus.cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        neg_res_q <= is_signed_d && (rs_q[W-1] ^ rt_q[W-1]);
                        neg_rem_q <= is_signed_d && is_div_d && rs_q[W-1];
                        div0_q    <= is_div_d && (rt_q == '0);
                        cnt_q     <= 5'(MULDIV_ITERS - 1);
                        opb_q     <= abs_rt_d;
                        if (is_div_d) begin
                            acc_q <= {{W{1'b0}}, abs_rs_d};
                            opa_q <= {{W{1'b0}}, abs_rt_d};
                        end else begin
                            acc_q <= '0;
                            opa_q <= {{W{1'b0}}, abs_rs_d};
                        end
                        state_q <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    if (bus.cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (is_div_d) begin
                            acc_q <= div_acc_d;
                        end else begin
                            acc_q <= mul_acc_d;
                            opa_q <= opa_q << 1;
                            opb_q <= opb_q >> 1;
                        end
                        cnt_q <= cnt_q - 5'd1;
                        if (iter_last_d) begin
                            state_q <= ST_FIX;
                        end
                    end
                end

                ST_FIX: begin
                    if (bus.cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= ST_DONE;
                        done_q       <= 1'b1;
                        hilo_d_q     <= result_d;
                        hilo_write_q <= 2'b11;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.hilo_d     = hilo_d_q;
    assign bus.hilo_write = hilo_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Counts DONE cycles using the pre-edge value of done.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [63:0] d;
        logic [1:0]  w;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    function automatic int mul_iters(input logic [31:0] m);
        int n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    // Reference behaviour from plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] d, output logic [1:0] w, output int lat);
        longint sp;
        int     qa, qb, q, r;
        logic [31:0] mabs;
        d = '0; w = 2'b11; lat = 35;
        case (op)
            3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); d = 64'(sp); end
            3'd1: d = 64'(a) * 64'(b);
            3'd2: begin
                if (b == 32'd0) d = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) d = {32'h0, 32'h80000000};
                else begin
                    qa = int'(a); qb = int'(b);
                    q = qa / qb; r = qa % qb;
                    d = {32'(r), 32'(q)};
                end
            end
            3'd3: d = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            3'd4: begin d = {a, a}; w = 2'b10; lat = 1; end
            3'd5: begin d = {a, a}; w = 2'b01; lat = 1; end
            default: begin w = 2'b00; lat = 0; end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 3'd0 || op == 3'd1) begin
            mabs = (op == 3'd0 && b[31]) ? (32'd0 - b) : b;
            lat = 3 + mul_iters(mabs);
        end
`else
        mabs = b;
        if (mabs === 32'hx) lat = -1;
`endif
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int inject,
                         output logic [63:0] d, output logic [1:0] w, output int lat);
        @(negedge clk);
        bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
        @(posedge clk);
        lat = 999; d = '0; w = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (inject != 0 && k == inject) begin
                bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hDEADBEEF;
            end
            if (inject != 0 && k == inject + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k; d = bus.hilo_d; w = bus.hilo_write;
                break;
            end
        end
        if (lat == 999) $display("FAIL timeout op=%0d: no done within 100 cycles", o);
    endtask

    task automatic run_check(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_d, input logic [1:0] exp_w, input int exp_lat, input int inject);
        logic [63:0] d;
        logic [1:0]  w;
        int          lat;
        int          c0;
        c0 = done_cnt;
        do_op(o, a, b, inject, d, w, lat);
        check({name, "_hilo_d"}, d, exp_d);
        check({name, "_write"}, 64'(w), 64'(exp_w));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check({name, "_write_after"}, 64'(bus.hilo_write), 64'd0);
        check({name, "_done_pulses"}, 64'(done_cnt - c0), 64'd1);
    endtask

    logic [63:0] md;
    logic [1:0]  mw;
    int          ml;
    int          c0;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 2'b11, 35};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2'b11, 35};
        vecs[2]  = '{3'd1, 32'h00000005, 32'h00000003, 64'h00000000_0000000F, 2'b11, 35};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 2'b11, 35};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 2'b11, 35};
        vecs[5]  = '{3'd3, 32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, 2'b11, 35};
        vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 2'b11, 35};
        vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 2'b11, 35};
        vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h0000000A, 64'h00000005_19999999, 2'b11, 35};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2'b11, 35};
        vecs[10] = '{3'd5, 32'h12345678, 32'h00000000, 64'h12345678_12345678, 2'b01, 1};
        vecs[11] = '{3'd4, 32'h9ABCDEF0, 32'h00000000, 64'h9ABCDEF0_9ABCDEF0, 2'b10, 1};

        bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.cancel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hilo_d", bus.hilo_d, 64'd0);
        check("reset_write", 64'(bus.hilo_write), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            int exp_lat;
            exp_lat = vecs[i].lat;
`ifdef MULDIV_EARLY_OUT_EN
            if (vecs[i].op < 3'd2) begin
                model(vecs[i].op, vecs[i].rs, vecs[i].rt, md, mw, ml);
                exp_lat = ml;
            end
`endif
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                      vecs[i].d, vecs[i].w, exp_lat, 0);
        end

        // No-op codes are ignored
        c0 = done_cnt;
        @(negedge clk);
        bus.op = 3'd6; bus.start = 1'b1;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        check("noop_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        check("noop_no_done", 64'(done_cnt - c0), 64'd0);

        // Cancel together with start in IDLE drops the start
        c0 = done_cnt;
        bus.op = 3'd4; bus.rs_val = 32'h55555555; bus.start = 1'b1; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("cancel_start_busy", 64'(bus.busy), 64'd0);
        check("cancel_start_no_done", 64'(done_cnt - c0), 64'd0);

        // MTLO then MTHI back to back (second start taken in the DONE cycle)
        bus.op = 3'd5; bus.rs_val = 32'h12345678; bus.start = 1'b1;
        @(negedge clk);
        check("b2b_mtlo_done", 64'(bus.done), 64'd1);
        check("b2b_mtlo_write", 64'(bus.hilo_write), 64'd1);
        check("b2b_mtlo_lo", 64'(bus.hilo_d[31:0]), 64'h12345678);
        bus.op = 3'd4; bus.rs_val = 32'hCAFEF00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_mthi_done", 64'(bus.done), 64'd1);
        check("b2b_mthi_write", 64'(bus.hilo_write), 64'd2);
        check("b2b_mthi_hi", 64'(bus.hilo_d[63:32]), 64'hCAFEF00D);
        @(negedge clk);
        check("b2b_idle_done", 64'(bus.done), 64'd0);

        // Start while busy is ignored: DIVU 1000/7 with an MTHI request mid-run
        run_check("busy_ignore", 3'd3, 32'd1000, 32'd7, {32'd6, 32'd142}, 2'b11, 35, 5);

        // Cancel mid-ITER, second start, then reset mid-ITER
        c0 = done_cnt;
        @(negedge clk);
        bus.op = 3'd0; bus.rs_val = 32'd1234; bus.rt_val = 32'd5678; bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                check("cancel_seq_busy", 64'(bus.busy), 64'd1);
            end
            if (k == 10) bus.cancel = 1'b1;
            if (k == 11) begin
                bus.cancel = 1'b0;
                check("cancel_busy_drop", 64'(bus.busy), 64'd0);
            end
            if (k == 12) begin
                bus.op = 3'd0; bus.rs_val = 32'h0000BEEF; bus.rt_val = 32'h00001111; bus.start = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("second_busy", 64'(bus.busy), 64'd1);
        check("cancel_no_done", 64'(done_cnt - c0), 64'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_done", 64'(bus.done), 64'd0);
        check("midreset_hilo_d", bus.hilo_d, 64'd0);
        check("midreset_write", 64'(bus.hilo_write), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 64'(done_cnt - c0), 64'd0);
        check("midreset_idle_busy", 64'(bus.busy), 64'd0);

        // Randomized operations against the reference model
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(0, 15));
                default: ;
            endcase
            model(rop, ra, rb, md, mw, ml);
            run_check($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, md, mw, ml, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
